// File: rtl/tap_scheduler.sv
// Delay-line tap scheduler: one memory write plus up to three tap reads per audio sample,
// with a triangle-wave LFO sweeping the chorus tap delay between CHOR_MIN and CHOR_MAX.
module tap_scheduler #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned REV_DELAY = 3000,
  parameter int unsigned CHOR_MIN  = 300,
  parameter int unsigned CHOR_MAX  = 900,
  parameter int unsigned LFO_DIV   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              chorus_on,
  input  logic              reverb_on,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              main_load,
  output logic              chor_load,
  output logic              rev_load,
  output logic              tfr_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned LfoW = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;
  localparam logic [ADDR_W-1:0] RevOff   = ADDR_W'(REV_DELAY);
  localparam logic [ADDR_W-1:0] ChorMinA = ADDR_W'(CHOR_MIN);
  localparam logic [ADDR_W-1:0] ChorMaxA = ADDR_W'(CHOR_MAX);
  localparam logic [LfoW-1:0]   LfoLast  = LfoW'(LFO_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdMain,
    StRdChor,
    StRdRev,
    StFlush,
    StDone
  } state_e;

  state_e            state;
  logic              chor_en;
  logic              rev_en;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] chor_delay;
  logic              dir_up;
  logic [LfoW-1:0]   lfo_cnt;

  logic [ADDR_W-1:0] chor_addr;
  logic [ADDR_W-1:0] rev_addr;
  logic [ADDR_W-1:0] chor_step;
  logic [ADDR_W-1:0] wr_ptr_inc;

  // Tap addresses wrap naturally in ADDR_W bits.
  assign chor_addr  = wr_ptr - chor_delay;
  assign rev_addr   = wr_ptr - RevOff;
  assign chor_step  = dir_up ? (chor_delay + 1'b1) : (chor_delay - 1'b1);
  assign wr_ptr_inc = wr_ptr + 1'b1;

  // Outputs are registered alongside the state, so each branch loads the values
  // that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      chor_en     <= 1'b0;
      rev_en      <= 1'b0;
      wr_ptr      <= '0;
      chor_delay  <= ChorMinA;
      dir_up      <= 1'b1;
      lfo_cnt     <= '0;
      mem_address <= '0;
      mem_write   <= 1'b0;
      main_load   <= 1'b0;
      chor_load   <= 1'b0;
      rev_load    <= 1'b0;
      tfr_ready   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      main_load <= 1'b0;
      chor_load <= 1'b0;
      rev_load  <= 1'b0;
      tfr_ready <= 1'b0;

      if (wr_req && (state != StIdle)) begin
        overrun <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          mem_address <= wr_ptr;
          if (wr_req) begin
            state     <= StWrite;
            chor_en   <= chorus_on;
            rev_en    <= reverb_on;
            mem_write <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StWrite: begin
          state       <= StRdMain;
          mem_address <= wr_ptr;
        end
        StRdMain: begin
          main_load <= 1'b1;
          if (chor_en) begin
            state       <= StRdChor;
            mem_address <= chor_addr;
          end else if (rev_en) begin
            state       <= StRdRev;
            mem_address <= rev_addr;
          end else begin
            state       <= StFlush;
            mem_address <= wr_ptr;
          end
        end
        StRdChor: begin
          chor_load <= 1'b1;
          if (rev_en) begin
            state       <= StRdRev;
            mem_address <= rev_addr;
          end else begin
            state       <= StFlush;
            mem_address <= wr_ptr;
          end
        end
        StRdRev: begin
          rev_load    <= 1'b1;
          state       <= StFlush;
          mem_address <= wr_ptr;
        end
        StFlush: begin
          state       <= StDone;
          tfr_ready   <= 1'b1;
          mem_address <= wr_ptr;
        end
        StDone: begin
          state       <= StIdle;
          busy        <= 1'b0;
          wr_ptr      <= wr_ptr_inc;
          mem_address <= wr_ptr_inc;
          if (lfo_cnt == LfoLast) begin
            lfo_cnt    <= '0;
            chor_delay <= chor_step;
            // Turn around on arrival at either end so the sweep never overshoots.
            if (chor_step == ChorMaxA) begin
              dir_up <= 1'b0;
            end else if (chor_step == ChorMinA) begin
              dir_up <= 1'b1;
            end
          end else begin
            lfo_cnt <= lfo_cnt + 1'b1;
          end
        end
        default: begin
          state       <= StIdle;
          busy        <= 1'b0;
          mem_address <= wr_ptr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_scheduler.sv
// Self-checking bench for tap_scheduler: directed vectors, a reset corner case and a long
// randomized run checked cycle by cycle against a sample-level reference model.
module tb_tap_scheduler;

  localparam int AW   = 12;
  localparam int REV  = 3000;
  localparam int CMIN = 300;
  localparam int CMAX = 900;
  localparam int DIV  = 16;
  localparam int MODN = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic          chorus_on;
  logic          reverb_on;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic          main_load;
  logic          chor_load;
  logic          rev_load;
  logic          tfr_ready;
  logic          busy;
  logic          overrun;

  tap_scheduler #(
    .ADDR_W   (AW),
    .REV_DELAY(REV),
    .CHOR_MIN (CMIN),
    .CHOR_MAX (CMAX),
    .LFO_DIV  (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .chorus_on  (chorus_on),
    .reverb_on  (reverb_on),
    .mem_address(mem_address),
    .mem_write  (mem_write),
    .main_load  (main_load),
    .chor_load  (chor_load),
    .rev_load   (rev_load),
    .tfr_ready  (tfr_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit c;
    bit r;
    int lat;
    int nm;
    int nc;
    int nr;
  } vec_rec_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_done;   // samples completed since the last reset
  bit  ovr_exp;

  // Packed view: {write, main, chor, rev, tfr, busy, overrun, address}
  function automatic logic [18:0] obs();
    return {mem_write, main_load, chor_load, rev_load, tfr_ready, busy, overrun, mem_address};
  endfunction

  function automatic logic [18:0] mk(bit w, bit m, bit c, bit r, bit t, bit b, bit o, int a);
    logic [AW-1:0] av;
    av = AW'(a);
    return {w, m, c, r, t, b, o, av};
  endfunction

  // Chorus delay is a triangle wave of the step count floor(n / DIV).
  function automatic int model_delay(int n);
    int s, span, ph;
    span = CMAX - CMIN;
    s    = n / DIV;
    ph   = s % (2 * span);
    return (ph <= span) ? (CMIN + ph) : (CMIN + 2 * span - ph);
  endfunction

  function automatic int wrap(int x);
    return ((x % MODN) + MODN) % MODN;
  endfunction

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got w%b m%b c%b r%b t%b b%b o%b addr=%0d, want w%b m%b c%b r%b t%b b%b o%b addr=%0d",
               name, got[18], got[17], got[16], got[15], got[14], got[13], got[12], got[11:0],
               exp[18], exp[17], exp[16], exp[15], exp[14], exp[13], exp[12], exp[11:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    wr_req    = 1'b0;
    chorus_on = 1'b0;
    reverb_on = 1'b0;
    tick();
    check("reset state", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    n_done  = 0;
    ovr_exp = 1'b0;
  endtask

  // Issues one sample from IDLE and checks every cycle up to and including the return to IDLE.
  // inj >= 0 drives a stray wr_req on that cycle index (must be while busy).
  task automatic run_sample(input bit c, input bit r, input int inj);
    int p, d, nr, a;
    int addrs[3];
    int kinds[3];
    bit w, m, cl, rl, t, b;
    p  = n_done % MODN;
    d  = model_delay(n_done);
    nr = 0;
    addrs[nr] = p; kinds[nr] = 0; nr++;
    if (c) begin addrs[nr] = wrap(p - d);   kinds[nr] = 1; nr++; end
    if (r) begin addrs[nr] = wrap(p - REV); kinds[nr] = 2; nr++; end
    wr_req = 1'b1; chorus_on = c; reverb_on = r;
    tick();
    wr_req = 1'b0; chorus_on = ~c; reverb_on = ~r;
    for (int j = 0; j <= nr + 3; j++) begin
      w = 0; m = 0; cl = 0; rl = 0; t = 0;
      b = (j <= nr + 2);
      a = p;
      if (j == 0) w = 1;
      if (j >= 1 && j <= nr) a = addrs[j-1];
      if (j >= 2 && j <= nr + 1) begin
        case (kinds[j-2])
          0:       m  = 1;
          1:       cl = 1;
          default: rl = 1;
        endcase
      end
      if (j == nr + 2) t = 1;
      if (j == nr + 3) a = (p + 1) % MODN;
      check($sformatf("smp%0d cyc%0d", n_done, j), obs(), mk(w, m, cl, rl, t, b, ovr_exp, a));
      wr_req = (j == inj);
      if (j == inj) ovr_exp = 1'b1;
      if (j < nr + 3) tick();
    end
    wr_req = 1'b0;
    n_done++;
  endtask

  vec_rec_t tbl[4];

  initial begin
    int k, cm, cc, cr, lat, nr, inj;
    bit c, r;

    tbl[0] = '{1, 1, 6, 1, 1, 1};
    tbl[1] = '{1, 0, 5, 1, 1, 0};
    tbl[2] = '{0, 1, 5, 1, 0, 1};
    tbl[3] = '{0, 0, 4, 1, 0, 0};

    do_reset();

    // Both taps from wr_ptr=0: exact address and strobe sequence.
    wr_req = 1'b1; chorus_on = 1'b1; reverb_on = 1'b1;
    tick();
    wr_req = 1'b0; chorus_on = 1'b0; reverb_on = 1'b0;
    check("T+1 write",    obs(), mk(1, 0, 0, 0, 0, 1, 0, 0));    tick();
    check("T+2 rd main",  obs(), mk(0, 0, 0, 0, 0, 1, 0, 0));    tick();
    check("T+3 rd chor",  obs(), mk(0, 1, 0, 0, 0, 1, 0, 3796)); tick();
    check("T+4 rd rev",   obs(), mk(0, 0, 1, 0, 0, 1, 0, 1096)); tick();
    check("T+5 flush",    obs(), mk(0, 0, 0, 1, 0, 1, 0, 0));    tick();
    check("T+6 done",     obs(), mk(0, 0, 0, 0, 1, 1, 0, 0));    tick();
    check("T+7 idle ptr", obs(), mk(0, 0, 0, 0, 0, 0, 0, 1));
    n_done = 1;

    // Latency and strobe counts per tap combination.
    foreach (tbl[i]) begin
      wr_req = 1'b1; chorus_on = tbl[i].c; reverb_on = tbl[i].r;
      tick();
      wr_req = 1'b0;
      k = 1; cm = 0; cc = 0; cr = 0; lat = -1;
      while (k < 20) begin
        cm += int'(main_load); cc += int'(chor_load); cr += int'(rev_load);
        if (tfr_ready) begin lat = k; break; end
        tick();
        k++;
      end
      check_int($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      check_int($sformatf("tbl%0d main_load", i), cm, tbl[i].nm);
      check_int($sformatf("tbl%0d chor_load", i), cc, tbl[i].nc);
      check_int($sformatf("tbl%0d rev_load", i), cr, tbl[i].nr);
      tick();
      n_done++;
    end

    // Dropped request at T+2 sets sticky overrun; sample and next request unaffected.
    do_reset();
    run_sample(1, 0, 1);
    run_sample(0, 0, -1);
    run_sample(1, 1, -1);

    // Reset at T+3 abandons the sample; a coincident wr_req is ignored.
    do_reset();
    wr_req = 1'b1; chorus_on = 1'b1; reverb_on = 1'b1;
    tick();                      // T+1
    wr_req = 1'b0;
    tick();                      // T+2
    wr_req = 1'b1;               // dropped, sets overrun
    tick();                      // T+3
    check("pre-reset overrun", obs(), mk(0, 1, 0, 0, 0, 1, 1, 3796));
    reset = 1'b1;
    tick();                      // T+4
    check("mid reset clears", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("post reset idle%0d", i), obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
      tick();
    end
    n_done = 0; ovr_exp = 1'b0;

    // Long randomized run covering a full LFO rise, the turn-around and a wr_ptr wrap.
    do_reset();
    for (int i = 0; i < DIV * 601 + 300; i++) begin
      c   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 3) == 0);
      nr  = 1 + int'(c) + int'(r);
      inj = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, nr + 2)) : -1;
      run_sample(c, r, inj);
      if ($urandom_range(0, 7) == 0) begin
        tick();
        check($sformatf("gap idle%0d", i), obs(),
              mk(0, 0, 0, 0, 0, 0, ovr_exp, n_done % MODN));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
